// File: rtl/comp_arb_pkg.sv
// Shared types for the comparator-sharing arbiter: FSM states, compare result bundle, data width.
package comp_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, CMP, RSP} arb_state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_res_t;

endpackage

// File: rtl/comp_32b.sv
// 32-bit unsigned magnitude comparator; exactly one of eq/lt/gt is set for any input pair.
module comp_32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq,
  output logic        lt,
  output logic        gt
);

  assign eq = (a == b);
  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/comp_rr_pick.sv
// Combinational round-robin picker: grants the first set request strictly after ptr, wrapping at N_REQ.
module comp_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  int               w_j;
  logic [ID_W-1:0]  w_idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_j     = 0;
    w_idx   = '0;
    // Scan offsets 1..N_REQ so the requester at ptr is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      w_j = int'(ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      w_idx = ID_W'(w_j);
      if (!any && req[w_idx]) begin
        any           = 1'b1;
        gnt_oh[w_idx] = 1'b1;
        gnt_idx       = w_idx;
      end
    end
  end

endmodule

// File: rtl/comp_share_arb.sv
// Round-robin arbiter sharing one comp_32b between N_REQ requesters; one transaction at a time,
// result returned with the requester id on a valid/ready response channel.
module comp_share_arb
  import comp_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    rsp_eq,
  output logic                    rsp_lt,
  output logic                    rsp_gt,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_cnt,
  output arb_state_t              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready. Requesters hold
  // req_valid and operands until req_ready; the response holds rsp_valid/id/result until rsp_ready.

  arb_state_t          r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  cmp_res_t            r_res;
  logic                r_rsp_valid;
  logic                r_busy;
  logic [CNT_W-1:0]    r_done_cnt;

  logic [N_REQ-1:0]    w_gnt_oh;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  cmp_res_t            w_cmp;

  comp_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt_oh  (w_gnt_oh),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // Only the granted slice is muxed out, so other requesters' operands never reach state.
  assign w_sel_a = req_a[int'(w_gnt_idx)*DATA_W +: DATA_W];
  assign w_sel_b = req_b[int'(w_gnt_idx)*DATA_W +: DATA_W];

  comp_32b u_cmp (
    .a  (r_op_a),
    .b  (r_op_b),
    .eq (w_cmp.eq),
    .lt (w_cmp.lt),
    .gt (w_cmp.gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= ID_W'(N_REQ - 1);
      r_id        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res       <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_id    <= w_gnt_idx;
            r_busy  <= 1'b1;
            r_state <= CMP;
          end
        end
        CMP: begin
          r_res       <= w_cmp;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            r_rr_ptr    <= r_id;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE) ? w_gnt_oh : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_eq    = r_res.eq;
  assign rsp_lt    = r_res.lt;
  assign rsp_gt    = r_res.gt;
  assign busy      = r_busy;
  assign done_cnt  = r_done_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_comp_share_arb.sv
// Bench for comp_share_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_comp_share_arb;
  import comp_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_a, req_b;
  logic            rsp_ready;
  logic [N-1:0]    req_ready, req_ready2;
  logic            rsp_valid, rsp_eq, rsp_lt, rsp_gt;
  logic            rsp_valid2, rsp_eq2, rsp_lt2, rsp_gt2;
  logic [IW-1:0]   rsp_id, rsp_id2;
  logic            busy, busy2;
  logic [CW-1:0]   done_cnt;
  logic [1:0]      done_cnt2;
  arb_state_t      dbg_state, dbg_state2;

  int checks = 0;
  int failures = 0;
  int m_last;
  int m_cnt;
  logic [31:0] a_arr[N];
  logic [31:0] b_arr[N];
  logic [IW+2:0] exp_q[$];

  comp_share_arb #(.N_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .rsp_gt(rsp_gt),
    .busy(busy), .done_cnt(done_cnt), .dbg_state(dbg_state)
  );

  // Narrow-counter instance sees identical stimulus; used for the wrap checks.
  comp_share_arb #(.N_REQ(N), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id2), .rsp_eq(rsp_eq2), .rsp_lt(rsp_lt2), .rsp_gt(rsp_gt2),
    .busy(busy2), .done_cnt(done_cnt2), .dbg_state(dbg_state2)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [2:0] model_cmp(input logic [31:0] a, input logic [31:0] b);
    return {a == b, a < b, a > b};
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    logic [N-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [N-1:0] v);
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_arr[i];
      req_b[32*i +: 32] = b_arr[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_arr[i] = $urandom;
      case ($urandom_range(0, 3))
        0: b_arr[i] = a_arr[i];
        1: b_arr[i] = a_arr[i] ^ 32'h8000_0000;
        default: b_arr[i] = $urandom;
      endcase
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    m_last = N - 1;
    m_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    next_cycle(); next_cycle();
    sample();
    checks++; if (dbg_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if ({rsp_id, rsp_eq, rsp_lt, rsp_gt} !== '0) begin failures++; $display("FAIL reset_rsp got=%b exp=0", {rsp_id, rsp_eq, rsp_lt, rsp_gt}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done_cnt !== '0 || done_cnt2 !== '0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0", done_cnt, done_cnt2); end
    next_cycle();
    rst = 1'b0; m_last = N - 1; m_cnt = 0;
  endtask

  task automatic test_single();
    for (int i = 0; i < N; i++) begin a_arr[i] = '0; b_arr[i] = '0; end
    a_arr[0] = 32'h1234_5678; b_arr[0] = 32'h1234_5678;
    rsp_ready = 1'b1;
    drive(4'b0001);
    sample();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    next_cycle(); drive(4'b0000); sample();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_cmp got=v%b/b%b exp=v0/b1", rsp_valid, busy); end
    next_cycle(); sample();
    checks++; if ({rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt} !== 6'b1_00_100) begin failures++; $display("FAIL single_rsp got=%b exp=100100", {rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt}); end
    next_cycle(); sample();
    m_last = 0; m_cnt = 1;
    checks++; if (rsp_valid !== 1'b0 || done_cnt !== CW'(1)) begin failures++; $display("FAIL single_done got=v%b/c%0d exp=v0/c1", rsp_valid, done_cnt); end
  endtask

  task automatic test_unsigned();
    logic [31:0] ta[2];
    logic [31:0] tb[2];
    logic [2:0]  tr[2];
    ta[0] = 32'h0000_0001; tb[0] = 32'hFFFF_FFFF; tr[0] = 3'b010;
    ta[1] = 32'h8000_0000; tb[1] = 32'h7FFF_FFFF; tr[1] = 3'b001;
    for (int t = 0; t < 2; t++) begin
      next_cycle();
      a_arr[2] = ta[t]; b_arr[2] = tb[t];
      drive(4'b0100);
      sample();
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL unsigned_ready%0d got=%b exp=0100", t, req_ready); end
      next_cycle(); drive(4'b0000);
      next_cycle(); sample();
      checks++; if ({rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt} !== {1'b1, 2'd2, tr[t]}) begin failures++; $display("FAIL unsigned_rsp%0d got=%b exp=%b", t, {rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_gt}, {1'b1, 2'd2, tr[t]}); end
      m_last = 2; m_cnt++;
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] v, rem;
    logic [IW+2:0] held, exp;
    int g, g2;
    rand_ops();
    v = 4'b1011;
    g = model_pick(v, m_last);
    rsp_ready = 1'b0;
    drive(v);
    sample();
    checks++; if (req_ready !== onehot(g)) begin failures++; $display("FAIL bp_grant got=%b exp=%b", req_ready, onehot(g)); end
    rem = v & ~onehot(g);
    next_cycle(); drive(rem);
    next_cycle();
    exp = {IW'(g), model_cmp(a_arr[g], b_arr[g])};
    for (int c = 0; c < 5; c++) begin
      sample();
      held = {rsp_id, rsp_eq, rsp_lt, rsp_gt};
      checks++; if (rsp_valid !== 1'b1 || held !== exp) begin failures++; $display("FAIL bp_hold%0d got=v%b/%b exp=v1/%b", c, rsp_valid, held, exp); end
      checks++; if (busy !== 1'b1 || req_ready !== '0) begin failures++; $display("FAIL bp_busy%0d got=b%b/r%b exp=b1/r0", c, busy, req_ready); end
      next_cycle();
    end
    rsp_ready = 1'b1;
    sample();
    checks++; if (rsp_valid !== 1'b1 || done_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL bp_release got=v%b/c%0d exp=v1/c%0d", rsp_valid, done_cnt, m_cnt); end
    m_last = g; m_cnt++;
    next_cycle(); sample();
    // Pending requests are only granted once back in IDLE.
    g2 = model_pick(rem, m_last);
    checks++; if (dbg_state !== IDLE || rsp_valid !== 1'b0 || done_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL bp_idle got=s%0d/v%b/c%0d exp=s0/v0/c%0d", dbg_state, rsp_valid, done_cnt, m_cnt); end
    checks++; if (req_ready !== onehot(g2)) begin failures++; $display("FAIL bp_next_grant got=%b exp=%b", req_ready, onehot(g2)); end
    next_cycle(); drive(4'b0000);
    next_cycle(); sample();
    exp = {IW'(g2), model_cmp(a_arr[g2], b_arr[g2])};
    checks++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_eq, rsp_lt, rsp_gt} !== exp) begin failures++; $display("FAIL bp_next_rsp got=%b exp=%b", {rsp_id, rsp_eq, rsp_lt, rsp_gt}, exp); end
    m_last = g2; m_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_mid();
    rand_ops();
    drive(4'b0001);
    next_cycle(); drive(4'b0000);
    sample();
    checks++; if (dbg_state !== CMP) begin failures++; $display("FAIL mid_in_cmp got=%0d exp=%0d", dbg_state, CMP); end
    rst = 1'b1;
    next_cycle(); rst = 1'b0; sample();
    m_last = N - 1; m_cnt = 0;
    checks++; if (dbg_state !== IDLE || rsp_valid !== 1'b0 || done_cnt !== '0) begin failures++; $display("FAIL mid_reset got=s%0d/v%b/c%0d exp=s0/v0/c0", dbg_state, rsp_valid, done_cnt); end
    for (int c = 0; c < 4; c++) begin
      next_cycle(); sample();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_no_rsp%0d got=v%b/b%b exp=v0/b0", c, rsp_valid, busy); end
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int g;
    apply_reset();
    rand_ops();
    drive(4'b1111);
    for (int t = 0; t < 8; t++) begin
      sample();
      g = model_pick(4'b1111, m_last);
      checks++; if (req_ready !== onehot(t % N) || req_ready !== onehot(g)) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", t, req_ready, onehot(t % N)); end
      checks++; if (rsp_valid !== 1'b0 || done_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL rr_idle%0d got=v%b/c%0d exp=v0/c%0d", t, rsp_valid, done_cnt, m_cnt); end
      next_cycle(); sample();
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rr_cmp%0d got=%b exp=0", t, rsp_valid); end
      next_cycle(); sample();
      checks++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_eq, rsp_lt, rsp_gt} !== {IW'(t % N), model_cmp(a_arr[g], b_arr[g])}) begin failures++; $display("FAIL rr_rsp%0d got=v%b/%b exp=v1/%b", t, rsp_valid, {rsp_id, rsp_eq, rsp_lt, rsp_gt}, {IW'(t % N), model_cmp(a_arr[g], b_arr[g])}); end
      m_last = g; m_cnt++;
      next_cycle();
    end
    drive(4'b0000);
  endtask

  task automatic test_counter_wrap();
    int wrap_tbl[5] = '{1, 2, 3, 0, 1};
    apply_reset();
    for (int t = 0; t < 5; t++) begin
      rand_ops();
      drive(4'($urandom_range(1, 15)));
      next_cycle(); drive(4'b0000);
      next_cycle(); next_cycle(); sample();
      m_cnt++;
      checks++; if (done_cnt2 !== 2'(wrap_tbl[t]) || done_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL wrap%0d got=%0d/%0d exp=%0d/%0d", t, done_cnt2, done_cnt, wrap_tbl[t], m_cnt); end
      next_cycle();
    end
    m_last = -1;
  endtask

  task automatic test_random();
    logic [N-1:0]  v;
    logic [IW+2:0] exp;
    int g, k;
    bit hs;
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      rand_ops();
      v = 4'($urandom_range(1, 15));
      drive(v);
      sample();
      g = model_pick(v, m_last);
      checks++; if (req_ready !== onehot(g) || done_cnt !== CW'(m_cnt) || done_cnt2 !== 2'(m_cnt)) begin failures++; $display("FAIL rand_grant%0d got=%b/c%0d exp=%b/c%0d", t, req_ready, done_cnt, onehot(g), m_cnt); end
      exp_q.push_back({IW'(g), model_cmp(a_arr[g], b_arr[g])});
      next_cycle();
      // Accepted: every requester's operands may now change freely.
      rand_ops(); drive(4'($urandom_range(0, 15)));
      next_cycle();
      drive(4'b0000);
      hs = 1'b0; k = 0;
      while (!hs) begin
        rsp_ready = (k >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
        sample();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rand_valid%0d got=%b exp=1", t, rsp_valid); end
        if (rsp_ready) begin
          exp = exp_q.pop_front();
          checks++; if ({rsp_id, rsp_eq, rsp_lt, rsp_gt} !== exp) begin failures++; $display("FAIL rand_rsp%0d got=%b exp=%b", t, {rsp_id, rsp_eq, rsp_lt, rsp_gt}, exp); end
          hs = 1'b1;
        end
        next_cycle();
        k++;
      end
      m_last = g; m_cnt++;
    end
    sample();
    checks++; if (rsp_valid !== 1'b0 || done_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL rand_end got=v%b/c%0d exp=v0/c%0d", rsp_valid, done_cnt, m_cnt); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_last = N - 1; m_cnt = 0;
    test_reset();
    test_single();
    test_unsigned();
    test_backpressure();
    test_reset_mid();
    test_round_robin();
    test_counter_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
